bitseq_recorder: RTL and testbench
==================================

# bitseq_recorder

Single-channel bit-sequence recorder: the capture-side counterpart of the bit-sequence player in the multi-function debugger. Samples one synchronized input pin at a programmable bit rate after a programmable start delay and stores up to 2^AW bits in an internal 1-bit-wide RAM. Host logic reads the captured sequence back through a synchronous read port. Used as a logic-analyzer channel or as a loopback checker for player output.

## Interface
- AW, 14, RAM address width; capture depth = 2^AW bits
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start_trig  in  1  1-cycle arm/start pulse
- stop  in  1  1-cycle abort pulse
- len  in  AW+1  bits to capture; sampled at start
- rate_div  in  32  bit period = rate_div+1 clk; sampled at start
- phase_off  in  32  start delay in clk; sampled at start
- io_in  in  1  asynchronous input pin
- rd_en  in  1  read strobe
- rd_addr  in  AW  read address
- rd_bit  out  1  read data, valid 1 cycle after rd_en
- capturing  out  1  high in ARM, DELAY, CAPTURE
- done  out  1  high in DONE until next accepted start
- cap_cnt  out  AW+1  bits written in current/last capture

## Operation
- io_in passes a 2-FF synchronizer -> io_s; all sampling and edge detection uses io_s.
- Effective length L: len==0 -> 1; len>2^AW -> 2^AW; else len. len, rate_div, phase_off latched on accepted start.
- States: IDLE, ARM (macro only), DELAY, CAPTURE, DONE.
- IDLE/DONE + start_trig: cap_cnt<=0, done<=0, phs_cnt<=phase_off, div_cnt<=0, wr_ptr<=0; next state DELAY (or ARM with macro).
- DELAY: phs_cnt!=0 -> decrement; phs_cnt==0 -> CAPTURE, div_cnt<=0. DELAY lasts phase_off+1 cycles.
- CAPTURE: div_cnt==rate_div -> mem[wr_ptr]<=io_s, wr_ptr++, cap_cnt++, div_cnt<=0; if this was bit L-1 -> DONE, done<=1. Else div_cnt++.
- stop in ARM/DELAY/CAPTURE -> IDLE; cap_cnt and RAM contents kept; done stays 0. stop in IDLE/DONE ignored.
- start_trig while capturing ignored. start_trig and stop same cycle: in IDLE/DONE start wins; while capturing stop wins.
- Read port independent of state: rd_en -> rd_bit<=mem[rd_addr] next cycle; rd_bit holds when rd_en low. Read of the address being written in the same cycle returns the old value.
- RAM is not reset; contents beyond cap_cnt are undefined.

## Timing
- Reset (rst_n low at clk edge): state IDLE, capturing=0, done=0, cap_cnt=0, rd_bit=0, internal counters 0, synchronizer FFs 0. Reset mid-capture aborts immediately; RAM unchanged.
- io_in -> io_s latency: 2 cycles.
- Start accepted at edge T: capturing=1 from T+1. First CAPTURE cycle at T+1+phase_off+1. Bit k sampled in CAPTURE cycle index k*(rate_div+1)+rate_div (0-based).
- done and capturing change on the same edge as the write of bit L-1; cap_cnt==L at that edge.
- div_cnt and phs_cnt are 32-bit, no overflow possible (compare-equal against latched value).

## Configuration
- BITSEQ_REC_EDGE_TRIG_EN defined: accepted start enters ARM; ARM waits for any io_s transition (io_s != previous io_s), then DELAY on next edge; phase_off counts from the detected edge. stop in ARM -> IDLE.
- Undefined: no ARM state; start goes directly to DELAY; edge detector not built.

## Test plan
- len=8, rate_div=0, phase_off=0, io_in driven with 8'b1011_0010 LSB-first, one bit per clk aligned to sampling -> done after 8 CAPTURE cycles, cap_cnt=8, readback addr 0..7 = 0,1,0,0,1,1,0,1.
- rate_div=3, phase_off=5, len=4, io_in constant 1 -> capturing high 6+16 cycles after start, mem[0..3]=1, done=1.
- len=0 -> exactly 1 bit captured, cap_cnt=1; len=2^AW+5 -> cap_cnt=2^AW, wr_ptr wraps to 0 without extra write.
- stop at CAPTURE bit 3 of len=10 -> IDLE, done=0, cap_cnt=3; start_trig+stop same cycle in IDLE -> capture starts.
- rst_n low mid-CAPTURE for 1 cycle -> all outputs reset next edge; previously written bits still read back correctly.
- With BITSEQ_REC_EDGE_TRIG_EN: start, io_in static 0 for 50 cycles -> no samples, capturing=1; rising edge -> capture begins phase_off+1 cycles after edge detected.

Source files
------------

// File: rtl/bitseq_recorder_if.sv
`default_nettype none
//==============================================================================
// Module   : bitseq_recorder_if
// Purpose  : Control, status and read-back bundle of the bit-sequence recorder.
// Revision : 1.0  initial release
//==============================================================================
interface bitseq_recorder_if #(
    parameter int AW = 14
) ();
    logic          start_trig;
    logic          stop;
    logic [AW:0]   len;
    logic [31:0]   rate_div;
    logic [31:0]   phase_off;
    logic          io_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_bit;
    logic          capturing;
    logic          done;
    logic [AW:0]   cap_cnt;

    modport master (
        output start_trig, stop, len, rate_div, phase_off, io_in, rd_en, rd_addr,
        input  rd_bit, capturing, done, cap_cnt
    );

    modport slave (
        input  start_trig, stop, len, rate_div, phase_off, io_in, rd_en, rd_addr,
        output rd_bit, capturing, done, cap_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bitseq_recorder.sv
`default_nettype none
//==============================================================================
// Module   : bitseq_recorder
// Purpose  : Samples one synchronized pin at a programmable bit rate after a
//            programmable delay into a 2^AW x 1 RAM with synchronous read-back.
// Options  : BITSEQ_REC_EDGE_TRIG_EN - start arms and waits for an io edge.
// Revision : 1.0  initial release
//==============================================================================
module bitseq_recorder #(
    parameter int AW = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    bitseq_recorder_if.slave  bus
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] C_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_io_s;
    logic          r_capturing;
    logic          r_done;
    logic [AW:0]   r_cap_cnt;
    logic [AW:0]   r_len_eff;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_div_cnt;
    logic [31:0]   r_phs_cnt;
    logic [31:0]   r_rate_div;
    logic          r_rd_bit;
    logic          r_mem [DEPTH];

    logic [AW:0]   w_len_eff;
    logic          w_bit_tick;
    logic          w_wr_en;
    logic          w_last;

    // Two-stage synchronizer for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_io_s  <= 1'b0;
        end else begin
            r_sync1 <= bus.io_in;
            r_io_s  <= r_sync1;
        end
    end

`ifdef BITSEQ_REC_EDGE_TRIG_EN
    logic        r_io_s_d;
    logic [31:0] r_phase_off;
    logic        w_edge;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_io_s_d <= 1'b0;
        end else begin
            r_io_s_d <= r_io_s;
        end
    end

    assign w_edge = r_io_s ^ r_io_s_d;
`endif

    always_comb begin
        w_len_eff = bus.len;
        if (bus.len == '0) begin
            w_len_eff = C_ONE;
        end else if (bus.len > C_DEPTH) begin
            w_len_eff = C_DEPTH;
        end
    end

    assign w_bit_tick = (r_state == S_CAPTURE) && (r_div_cnt == r_rate_div);
    // An abort or reset on the sampling edge suppresses the write.
    assign w_wr_en    = w_bit_tick && !bus.stop && rst_n;
    assign w_last     = (r_cap_cnt + C_ONE) == r_len_eff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_capturing <= 1'b0;
            r_done      <= 1'b0;
            r_cap_cnt   <= '0;
            r_len_eff   <= '0;
            r_wr_ptr    <= '0;
            r_div_cnt   <= '0;
            r_phs_cnt   <= '0;
            r_rate_div  <= '0;
`ifdef BITSEQ_REC_EDGE_TRIG_EN
            r_phase_off <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_trig) begin
                        r_capturing <= 1'b1;
                        r_done      <= 1'b0;
                        r_cap_cnt   <= '0;
                        r_wr_ptr    <= '0;
                        r_div_cnt   <= '0;
                        r_phs_cnt   <= bus.phase_off;
                        r_len_eff   <= w_len_eff;
                        r_rate_div  <= bus.rate_div;
`ifdef BITSEQ_REC_EDGE_TRIG_EN
                        r_phase_off <= bus.phase_off;
                        r_state     <= S_ARM;
`else
                        r_state     <= S_DELAY;
`endif
                    end
                end
`ifdef BITSEQ_REC_EDGE_TRIG_EN
                S_ARM: begin
                    if (bus.stop) begin
                        r_state     <= S_IDLE;
                        r_capturing <= 1'b0;
                    end else if (w_edge) begin
                        // The delay is measured from the detected transition.
                        r_phs_cnt <= r_phase_off;
                        r_state   <= S_DELAY;
                    end
                end
`endif
                S_DELAY: begin
                    if (bus.stop) begin
                        r_state     <= S_IDLE;
                        r_capturing <= 1'b0;
                    end else if (r_phs_cnt != '0) begin
                        r_phs_cnt <= r_phs_cnt - 1'b1;
                    end else begin
                        r_div_cnt <= '0;
                        r_state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (bus.stop) begin
                        r_state     <= S_IDLE;
                        r_capturing <= 1'b0;
                    end else if (w_bit_tick) begin
                        r_wr_ptr  <= r_wr_ptr + 1'b1;
                        r_cap_cnt <= r_cap_cnt + C_ONE;
                        r_div_cnt <= '0;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_capturing <= 1'b0;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_capturing <= 1'b0;
                end
            endcase
        end
    end

    // Capture RAM: never reset, so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_io_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_bit <= 1'b0;
        end else if (bus.rd_en) begin
            r_rd_bit <= r_mem[bus.rd_addr];
        end
    end

    assign bus.rd_bit    = r_rd_bit;
    assign bus.capturing = r_capturing;
    assign bus.done      = r_done;
    assign bus.cap_cnt   = r_cap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bitseq_recorder.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_bitseq_recorder
// Purpose  : Scoreboard bench for bitseq_recorder with a timeline-based model.
// Revision : 1.0  initial release
//==============================================================================
module tb_bitseq_recorder;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int HMAX  = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bitseq_recorder_if #(.AW(AW)) bus ();
    bitseq_recorder #(.AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   n_cmp = 0;
    int   n_bad = 0;
    logic sb [$];
    // hist[k] is the pin value presented at the k-th edge after the start edge
    bit   hist [HMAX];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit h(input int i);
        return (i < 0) ? 1'b0 : hist[i];
    endfunction

    // Edge offset (from the start edge) at which bit j is written.
    function automatic int ebit(input int a, input int ph, input int rd, input int j);
        return a + 2 + ph + j * (rd + 1) + rd;
    endfunction

    // Monitor: every read strobe produces one rd_bit one cycle later.
    initial begin
        bit   rd_v;
        logic e;
        forever begin
            @(posedge clk);
            rd_v = bus.rd_en && rst_n;
            #1;
            if (rd_v) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got rd_bit %0b expected none", bus.rd_bit);
                end else begin
                    e = sb.pop_front();
                    check("rd_bit", {63'd0, bus.rd_bit}, {63'd0, e});
                end
            end
        end
    end

    task automatic run_capture(input int ln, input int rd, input int ph, input int mode,
                               input logic [63:0] pat, input int stop_at, input int rst_bits,
                               input bit start_with_stop, input bit spurious_start);
        int L, a, e_last, rst_at, done_k, nbits;
        bit stopped, rst_hit, spur;
        for (int i = 0; i < HMAX; i++) begin
            case (mode)
                0:       hist[i] = 1'($urandom_range(0, 1));
                1:       hist[i] = (i < 64) ? pat[i] : 1'b0;
                default: hist[i] = (i >= 50);
            endcase
        end
        L = (ln == 0) ? 1 : ((ln > DEPTH) ? DEPTH : ln);
        a = 0;
`ifdef BITSEQ_REC_EDGE_TRIG_EN
        a = -1;
        for (int k = 1; k < HMAX - 400 && a < 0; k++) begin
            if (h(k - 2) != h(k - 3)) a = k;
        end
        if (a < 0) begin
            check("arm_edge_found", 64'd0, 64'd1);
            return;
        end
`endif
        e_last  = ebit(a, ph, rd, L - 1);
        rst_at  = (rst_bits > 0) ? ebit(a, ph, rd, rst_bits - 1) + 1 : -1;
        spur    = spurious_start && (e_last > 4);
        stopped = 1'b0;
        rst_hit = 1'b0;
        done_k  = -1;

        @(negedge clk);
        bus.start_trig = 1'b1;
        bus.stop       = start_with_stop;
        bus.len        = ln[AW:0];
        bus.rate_div   = rd;
        bus.phase_off  = ph;
        bus.io_in      = hist[0];
        @(negedge clk);
        bus.start_trig = 1'b0;
        bus.stop       = 1'b0;
        check("capturing_after_start", {63'd0, bus.capturing}, 64'd1);
        check("done_after_start", {63'd0, bus.done}, 64'd0);
        check("cap_cnt_after_start", 64'(bus.cap_cnt), 64'd0);

        for (int k = 1; k <= e_last + 4; k++) begin
            bus.io_in = hist[k];
            if (spur && k == 2) bus.start_trig = 1'b1;
            if (stop_at >= 0 && !stopped && int'(bus.cap_cnt) == stop_at) begin
                bus.stop = 1'b1;
                stopped  = 1'b1;
            end
            if (k == rst_at) begin
                rst_n   = 1'b0;
                rst_hit = 1'b1;
            end
            @(negedge clk);
            bus.start_trig = 1'b0;
            bus.stop       = 1'b0;
            rst_n          = 1'b1;
            if (mode == 2 && k == 45) begin
                check("armed_capturing", {63'd0, bus.capturing}, 64'd1);
                check("armed_cap_cnt", 64'(bus.cap_cnt), 64'd0);
            end
            if (stopped || rst_hit) break;
            if (bus.done) begin
                done_k = k;
                break;
            end
        end
        bus.io_in = 1'b0;

        if (rst_hit) begin
            check("rst_capturing", {63'd0, bus.capturing}, 64'd0);
            check("rst_done", {63'd0, bus.done}, 64'd0);
            check("rst_cap_cnt", 64'(bus.cap_cnt), 64'd0);
            check("rst_rd_bit", {63'd0, bus.rd_bit}, 64'd0);
            nbits = rst_bits;
        end else if (stop_at >= 0) begin
            check("stop_issued", {63'd0, stopped}, 64'd1);
            check("stop_capturing", {63'd0, bus.capturing}, 64'd0);
            check("stop_done", {63'd0, bus.done}, 64'd0);
            check("stop_cap_cnt", 64'(bus.cap_cnt), 64'(stop_at));
            nbits = stop_at;
        end else begin
            check("done_time", 64'(done_k), 64'(e_last));
            check("final_cap_cnt", 64'(bus.cap_cnt), 64'(L));
            check("final_capturing", {63'd0, bus.capturing}, 64'd0);
            check("final_done", {63'd0, bus.done}, 64'd1);
            nbits = L;
        end

        for (int j = 0; j < nbits; j++) begin
            @(negedge clk);
            bus.rd_en   = 1'b1;
            bus.rd_addr = j[AW-1:0];
            sb.push_back(hist[ebit(a, ph, rd, j) - 2]);
        end
        @(negedge clk);
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        if (nbits > 0) begin
            check("rd_hold", {63'd0, bus.rd_bit},
                  {63'd0, hist[ebit(a, ph, rd, nbits - 1) - 2]});
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start_trig = 1'b0;
        bus.stop       = 1'b0;
        bus.len        = '0;
        bus.rate_div   = '0;
        bus.phase_off  = '0;
        bus.io_in      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        repeat (3) @(negedge clk);
        check("reset_capturing", {63'd0, bus.capturing}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_cap_cnt", 64'(bus.cap_cnt), 64'd0);
        check("reset_rd_bit", {63'd0, bus.rd_bit}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_capture(8, 0, 0, 1, 64'hB2, -1, 0, 1'b0, 1'b0);
        run_capture(4, 3, 5, 1, '1, -1, 0, 1'b0, 1'b0);
        run_capture(0, 1, 2, 0, '0, -1, 0, 1'b0, 1'b0);
        run_capture(DEPTH + 5, 0, 3, 0, '0, -1, 0, 1'b0, 1'b0);
        run_capture(10, 1, 2, 0, '0, 3, 0, 1'b0, 1'b0);
        run_capture(6, 2, 1, 0, '0, -1, 0, 1'b1, 1'b0);
        run_capture(12, 2, 3, 0, '0, -1, 5, 1'b0, 1'b0);
`ifdef BITSEQ_REC_EDGE_TRIG_EN
        run_capture(5, 1, 4, 2, '0, -1, 0, 1'b0, 1'b0);
`endif
        for (int r = 0; r < 6; r++) begin
            run_capture(int'($urandom_range(1, 40)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 10)), 0, '0, -1, 0, 1'b0, 1'b1);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
